// File: rtl/th_calibrator.sv
// th_calibrator: averages 2^NF_LOG2 target-free frames per bin, adds an offset, and streams saturated thresholds to the RAM write port.
// Define TH_MAXHOLD_EN to keep each bin's maximum instead of its mean.
module th_calibrator #(
  parameter int IL      = 10,
  parameter int AW      = 17,
  parameter int BINS    = 1024,
  parameter int NF_LOG2 = 3
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCLR,
  input  logic          iSTART,
  input  logic [IL-1:0] iOFFSET,
  input  logic          iEN,
  input  logic [IL-1:0] iDATA,
  output logic          oBUSY,
  output logic          oWE,
  output logic [AW-1:0] oWADDR,
  output logic [IL-1:0] oWDATA,
  output logic          oDONE
);
  localparam int BW = (BINS > 1) ? $clog2(BINS) : 1;
  localparam int FW = (NF_LOG2 > 0) ? NF_LOG2 : 1;
`ifdef TH_MAXHOLD_EN
  localparam int AC = IL;
`else
  localparam int AC = IL + NF_LOG2;
`endif
  localparam logic [FW-1:0] LASTF = FW'((1 << NF_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bin_q, bin_d, rd_idx;
  logic [FW-1:0] frm_q, frm_d;
  logic [IL-1:0] off_q, off_d, wdata_q, wdata_d, mean, thr;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AC-1:0] acc [BINS];
  logic [AC-1:0] acc_rd, acc_nx;
  logic [IL:0]   sum;
  logic          acc_we;

  assign acc_we = (state_q == ACCUM) && iEN;
  // Read one address ahead so the registered write word is ready on the next cycle.
  assign rd_idx = (state_q == WRITE) ? BW'(waddr_q + AW'(1)) : '0;
  assign acc_rd = acc[rd_idx];
`ifdef TH_MAXHOLD_EN
  assign acc_nx = (frm_q == '0 || iDATA > acc[bin_q]) ? iDATA : acc[bin_q];
  assign mean   = acc_rd;
`else
  assign acc_nx = (frm_q == '0) ? AC'(iDATA) : acc[bin_q] + AC'(iDATA);
  assign mean   = IL'(acc_rd >> NF_LOG2);
`endif
  assign sum = {1'b0, mean} + {1'b0, off_q};
  assign thr = sum[IL] ? '1 : sum[IL-1:0];

  assign oBUSY  = (state_q == ACCUM) || (state_q == WRITE);
  assign oWE    = state_q == WRITE;
  assign oDONE  = state_q == DONE;
  assign oWADDR = waddr_q;
  assign oWDATA = wdata_q;

  always_ff @(posedge iCLK) begin
    if (acc_we) acc[bin_q] <= acc_nx;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    frm_d   = frm_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (iSTART) begin
        off_d   = iOFFSET;
        bin_d   = '0;
        frm_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: if (iEN) begin
        if (bin_q == BW'(BINS - 1)) begin
          bin_d = '0;
          frm_d = frm_q + FW'(1);
          if (frm_q == LASTF) begin
            state_d = WRITE;
            waddr_d = '0;
            wdata_d = thr;
          end
        end else begin
          bin_d = bin_q + BW'(1);
        end
      end
      WRITE: if (waddr_q == AW'(BINS - 1)) begin
        state_d = DONE;
      end else begin
        waddr_d = waddr_q + AW'(1);
        wdata_d = thr;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      state_q <= IDLE;
      bin_q   <= '0;
      frm_q   <= '0;
      off_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      frm_q   <= frm_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule
